afpm_host_driver: RTL
=====================

# afpm_host_driver

Host-side initiator for the logarithmic approximate FP multiplier (`tt_um_logarithmic_afpm`). It accepts a 16-bit operand pair (A, B) over a valid/ready handshake and serializes it onto the multiplier's 8-bit dedicated and bidirectional input pins as two byte beats, low byte first. After a fixed result latency it captures the two result bytes from `uo_out` and presents the 16-bit product over a valid/ready handshake. It sits between an operand source (on-chip sequencer or FPGA harness) and the multiplier's pin interface.

## Interface
- `RESULT_LAT`, 2: cycles between the high operand beat and the first result beat; legal range 0–15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `op_valid`  in  1  operand pair offered.
- `op_ready`  out  1  driver can accept an operand pair.
- `op_a`  in  16  operand A, FP16 bit pattern.
- `op_b`  in  16  operand B, FP16 bit pattern.
- `pin_a`  out  8  drives multiplier `ui_in`.
- `pin_b`  out  8  drives multiplier `uio_in`.
- `pin_res`  in  8  from multiplier `uo_out`.
- `res_valid`  out  1  captured product available.
- `res_ready`  in  1  consumer accepts the product.
- `res_data`  out  16  captured product, {high byte, low byte}.
- `busy`  out  1  high in every state except IDLE.
- `ops_done`  out  8  count of completed result handshakes; wraps from 255 to 0.

## Operation
- States: IDLE, SEND_LO, SEND_HI, WAIT, CAP_LO, CAP_HI, DONE.
- IDLE: `op_ready`=1. On `op_valid && op_ready`, latch A/B and go to SEND_LO.
- SEND_LO: `pin_a`=A[7:0], `pin_b`=B[7:0]. Next state SEND_HI.
- SEND_HI: `pin_a`=A[15:8], `pin_b`=B[15:8]. Next state WAIT, or CAP_LO if RESULT_LAT=0.
- WAIT: a down-counter loaded with RESULT_LAT−1 on entry; leave for CAP_LO when it reaches 0.
- CAP_LO: sample `pin_res` into `res_data[7:0]` at the closing edge. Next state CAP_HI.
- CAP_HI: sample `pin_res` into `res_data[15:8]`. Next state DONE.
- DONE: `res_valid`=1 and `res_data` held stable. On `res_ready`, increment `ops_done` and go to IDLE.
- `op_ready` is 0 in DONE, so a new op cannot be accepted in the same cycle as the result handshake. The earliest new accept is one cycle after it.
- `pin_a`/`pin_b` are registered and read 0x00 in every state other than SEND_LO and SEND_HI.
- `op_a`/`op_b` changes after acceptance have no effect.
- `res_ready` outside DONE is ignored.

## Timing
- Reset, asynchronous, from any state:
  - state=IDLE
  - `pin_a`=`pin_b`=0x00
  - `res_data`=0x0000
  - `res_valid`=0, `busy`=0, `ops_done`=0
  - `op_ready`=1 once reset is released
  - an in-flight operation is discarded; no partial result is ever presented.
- Take the accept edge as E0:
  - SEND_LO beat is driven in cycle E0→E1.
  - SEND_HI beat is driven in cycle E1→E2.
  - Result bytes are sampled at edges E(3+L) and E(4+L), where L=RESULT_LAT.
  - `res_valid` rises after E(4+L); with the default L=2 that is 6 cycles.
- Throughput with `res_ready` tied high: one op per 6+L cycles.
- `ops_done` increments on the DONE→IDLE edge only.

## Structure
- Shared package `afpm_pkg` holds:
  - the state enum `afpm_drv_state_t`
  - `AFPM_BEAT_W`=8 and `AFPM_WORD_W`=16
  - `AFPM_NUM_BEATS`=2.
- Single module, no sub-modules. The WAIT counter and the capture registers are inline.

## Test plan
- Reset defaults and mid-op reset:
  - After reset, all outputs are at their reset values.
  - Assert `rst_n`=0 during WAIT: outputs return to reset values immediately and `res_valid` never rises.
- Basic op, bench responder models the multiplier with L=2:
  - Stimulus A=0x3E00, B=0x4200.
  - Required pins: 0x00/0x00, then 0x3E/0x42, then 0x00.
  - Responder drives 0x80 then 0x44; required `res_data`=0x4480 six cycles after accept.
- Backpressure: hold `res_ready`=0 for 10 cycles in DONE.
  - `res_valid` and `res_data` stay stable; `op_ready`=0; a new `op_valid` is not accepted.
- RESULT_LAT=0 build: capture begins the cycle after SEND_HI; `res_valid` rises 4 cycles after accept.
- Back-to-back ops with `op_valid` and `res_ready` tied high:
  - One accept every 8 cycles.
  - `ops_done` counts 1, 2, 3 …; after 256 ops it wraps to 0.
- Operand stability: change `op_a` and `op_b` right after the accept edge; the pins still show the latched bytes.

Source files
------------

// File: rtl/afpm_pkg.sv
// Shared types and widths for the logarithmic FP multiplier host driver.
package afpm_pkg;

   localparam int AFPM_BEAT_W    = 8;
   localparam int AFPM_WORD_W    = 16;
   localparam int AFPM_NUM_BEATS = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND_LO = 3'd1,
      ST_SEND_HI = 3'd2,
      ST_WAIT    = 3'd3,
      ST_CAP_LO  = 3'd4,
      ST_CAP_HI  = 3'd5,
      ST_DONE    = 3'd6
   } afpm_drv_state_t;

endpackage

// File: rtl/afpm_host_driver.sv
// Host-side initiator for the logarithmic approximate FP multiplier.
// Serializes an operand pair onto the 8-bit pins as two beats (low first),
// waits a fixed latency, captures two result bytes and offers the product.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for an operand pair
// SEND_LO  | low operand bytes on pin_a/pin_b
// SEND_HI  | high operand bytes on pin_a/pin_b
// WAIT     | result latency down-counter running
// CAP_LO   | pin_res sampled into res_data[7:0] at the closing edge
// CAP_HI   | pin_res sampled into res_data[15:8] at the closing edge
// DONE     | product offered, waiting for res_ready
module afpm_host_driver
   import afpm_pkg::*;
#(
   parameter int unsigned RESULT_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [AFPM_WORD_W-1:0] op_a,
   input  logic [AFPM_WORD_W-1:0] op_b,
   output logic [AFPM_BEAT_W-1:0] pin_a,
   output logic [AFPM_BEAT_W-1:0] pin_b,
   input  logic [AFPM_BEAT_W-1:0] pin_res,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [AFPM_WORD_W-1:0] res_data,
   output logic                   busy,
   output logic [7:0]             ops_done
);

   // Counter preload; only meaningful when RESULT_LAT > 0.
   localparam logic [3:0] LAT_LOAD = (RESULT_LAT == 0) ? 4'd0 : 4'(RESULT_LAT - 1);

   afpm_drv_state_t        state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [AFPM_BEAT_W-1:0] a_hi_q, a_hi_d;
   logic [AFPM_BEAT_W-1:0] b_hi_q, b_hi_d;
   logic [AFPM_BEAT_W-1:0] pin_a_q, pin_a_d;
   logic [AFPM_BEAT_W-1:0] pin_b_q, pin_b_d;
   logic [AFPM_WORD_W-1:0] res_q, res_d;
   logic [7:0]             done_q, done_d;

   // Next-state, beat and capture decode; pins default to 0x00 outside the send beats.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_hi_d  = a_hi_q;
      b_hi_d  = b_hi_q;
      pin_a_d = '0;
      pin_b_d = '0;
      res_d   = res_q;
      done_d  = done_q;
      unique case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               // Low bytes go straight to the pin registers; only the high bytes need holding.
               pin_a_d = op_a[AFPM_BEAT_W-1:0];
               pin_b_d = op_b[AFPM_BEAT_W-1:0];
               a_hi_d  = op_a[AFPM_WORD_W-1:AFPM_BEAT_W];
               b_hi_d  = op_b[AFPM_WORD_W-1:AFPM_BEAT_W];
               state_d = ST_SEND_LO;
            end
         end
         ST_SEND_LO: begin
            pin_a_d = a_hi_q;
            pin_b_d = b_hi_q;
            state_d = ST_SEND_HI;
         end
         ST_SEND_HI: begin
            if (RESULT_LAT == 0) begin
               state_d = ST_CAP_LO;
            end else begin
               cnt_d   = LAT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_CAP_LO;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_CAP_LO: begin
            res_d[AFPM_BEAT_W-1:0] = pin_res;
            state_d                = ST_CAP_HI;
         end
         ST_CAP_HI: begin
            res_d[AFPM_WORD_W-1:AFPM_BEAT_W] = pin_res;
            state_d                          = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) begin
               done_d  = done_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_hi_q  <= '0;
         b_hi_q  <= '0;
         pin_a_q <= '0;
         pin_b_q <= '0;
         res_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_hi_q  <= a_hi_d;
         b_hi_q  <= b_hi_d;
         pin_a_q <= pin_a_d;
         pin_b_q <= pin_b_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign op_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign res_valid = (state_q == ST_DONE);
   assign pin_a     = pin_a_q;
   assign pin_b     = pin_b_q;
   assign res_data  = res_q;
   assign ops_done  = done_q;

endmodule
